// File: rtl/btn_reader.sv
// btn_reader: synchronizes, debounces and edge-detects board push-buttons, adding long-hold and auto-repeat pulses.
//   clk, rst (async, active-high) | btn_in: raw pins | pressed: debounced level (1 = pressed)
//   press_pulse/release_pulse: one cycle on pressed edges | hold_pulse: press lasted HOLD_CYCLES
//   rpt_pulse: every REPEAT_CYCLES once the hold point is passed
module btn_reader #(
  parameter int WIDTH           = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] hold_pulse,
  output logic [WIDTH-1:0] rpt_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic INACT = (ACTIVE_LOW != 0);
  typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic sync1_q, sync2_q, level, deb_done;
    logic pressed_q, pressed_d, press_pulse_q, release_pulse_q;
    logic hold_pulse_q, hold_pulse_d, rpt_pulse_q, rpt_pulse_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    state_t state_q, state_d;
    always_comb begin
      level = sync2_q ^ INACT;
      deb_done = (level != pressed_q) && (deb_cnt_q == DEB_LAST);
      pressed_d = deb_done ? level : pressed_q;
      // any sample agreeing with the stable state discards the partial count
      deb_cnt_d = (level == pressed_q || deb_done) ? '0 : deb_cnt_q + DW'(1);
    end
    // the hold machine follows pressed_d so that no hold/repeat pulse can
    // coincide with the release edge
    always_comb begin
      state_d = state_q;
      hold_cnt_d = hold_cnt_q;
      rpt_cnt_d = rpt_cnt_q;
      hold_pulse_d = 1'b0;
      rpt_pulse_d = 1'b0;
      if (!pressed_d) begin
        state_d = IDLE;
        hold_cnt_d = '0;
        rpt_cnt_d = '0;
      end else if (state_q == IDLE) begin
        state_d = PRESS;
        hold_cnt_d = '0;
      end else if (state_q == PRESS) begin
        hold_pulse_d = (hold_cnt_q == HOLD_LAST);
        state_d = hold_pulse_d ? HELD : PRESS;
        hold_cnt_d = hold_pulse_d ? '0 : hold_cnt_q + HW'(1);
        rpt_cnt_d = '0;
      end else begin
        rpt_pulse_d = (rpt_cnt_q == RPT_LAST);
        rpt_cnt_d = rpt_pulse_d ? '0 : rpt_cnt_q + RW'(1);
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= INACT;
        sync2_q <= INACT;
        pressed_q <= 1'b0;
        press_pulse_q <= 1'b0;
        release_pulse_q <= 1'b0;
        hold_pulse_q <= 1'b0;
        rpt_pulse_q <= 1'b0;
        deb_cnt_q <= '0;
        hold_cnt_q <= '0;
        rpt_cnt_q <= '0;
        state_q <= IDLE;
      end else begin
        sync1_q <= btn_in[i];
        sync2_q <= sync1_q;
        pressed_q <= pressed_d;
        press_pulse_q <= pressed_d & ~pressed_q;
        release_pulse_q <= ~pressed_d & pressed_q;
        hold_pulse_q <= hold_pulse_d;
        rpt_pulse_q <= rpt_pulse_d;
        deb_cnt_q <= deb_cnt_d;
        hold_cnt_q <= hold_cnt_d;
        rpt_cnt_q <= rpt_cnt_d;
        state_q <= state_d;
      end
    end
    assign pressed[i] = pressed_q;
    assign press_pulse[i] = press_pulse_q;
    assign release_pulse[i] = release_pulse_q;
    assign hold_pulse[i] = hold_pulse_q;
    assign rpt_pulse[i] = rpt_pulse_q;
  end
endmodule

// File: tb/tb_btn_reader.sv
// tb_btn_reader: directed self-checking bench for btn_reader.
module tb_btn_reader;
  logic clk, rst;
  logic [1:0] btn_in, pressed, press_pulse, release_pulse, hold_pulse, rpt_pulse;
  logic [9:0] obs;
  int checks = 0;
  int failures = 0;
  localparam logic [1:0] N = 2'b00, C0 = 2'b01, C1 = 2'b10, CB = 2'b11;
  localparam logic [9:0] Z = 10'b0;
  btn_reader #(
    .WIDTH(2), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(5)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .hold_pulse(hold_pulse), .rpt_pulse(rpt_pulse)
  );
  assign obs = {pressed, press_pulse, release_pulse, hold_pulse, rpt_pulse};
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  function automatic logic [9:0] v(input logic [1:0] p, pp, rp, hp, rr);
    return {p, pp, rp, hp, rr};
  endfunction
  task automatic chk(input string tag, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b (pressed,press,release,hold,rpt)", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input int n, input logic [9:0] exp);
    for (int i = 0; i < n; i++) begin
      step;
      chk(tag, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    btn_in = CB;
    run("reset", 3, Z);
    rst = 1'b0;
    run("post_reset", 5, Z);
    // clean press on channel 0, hold, repeats, release coinciding with a repeat slot
    btn_in = C1;
    run("clean_wait", 5, Z);
    step; chk("clean_press", v(C0, C0, N, N, N));
    run("hold_wait", 9, v(C0, N, N, N, N));
    step; chk("hold", v(C0, N, N, C0, N));
    for (int k = 0; k < 3; k++) begin
      run("rpt_wait", 4, v(C0, N, N, N, N));
      step; chk("rpt", v(C0, N, N, N, C0));
    end
    run("rpt_wait4", 4, v(C0, N, N, N, N));
    btn_in = CB;
    step; chk("rpt4", v(C0, N, N, N, C0));
    run("rel_wait", 4, v(C0, N, N, N, N));
    step; chk("release", v(N, N, C0, N, N));
    run("idle_after_rel", 10, Z);
    // three-cycle glitch: never accepted
    btn_in = C1;
    run("glitch", 3, Z);
    btn_in = CB;
    run("glitch_after", 10, Z);
    // bounce then steady low, then a short press
    btn_in = C1;
    run("bounce_a", 3, Z);
    btn_in = CB;
    run("bounce_b", 1, Z);
    btn_in = C1;
    run("bounce_c", 5, Z);
    step; chk("bounce_press", v(C0, C0, N, N, N));
    btn_in = CB;
    run("short_wait", 5, v(C0, N, N, N, N));
    step; chk("short_release", v(N, N, C0, N, N));
    run("short_idle", 15, Z);
    // reset while HELD, pin kept low through reset
    btn_in = C1;
    run("rh_wait", 5, Z);
    step; chk("rh_press", v(C0, C0, N, N, N));
    run("rh_hold_wait", 9, v(C0, N, N, N, N));
    step; chk("rh_hold", v(C0, N, N, C0, N));
    run("rh_held", 2, v(C0, N, N, N, N));
    #2 rst = 1'b1;
    #1 chk("rst_async", Z);
    run("in_reset", 2, Z);
    rst = 1'b0;
    run("rh_repress_wait", 5, Z);
    step; chk("rh_repress", v(C0, C0, N, N, N));
    run("rh_rehold_wait", 9, v(C0, N, N, N, N));
    step; chk("rh_rehold", v(C0, N, N, C0, N));
    btn_in = CB;
    run("rh_rel_wait", 4, v(C0, N, N, N, N));
    step; chk("rh_rpt", v(C0, N, N, N, C0));
    step; chk("rh_release", v(N, N, C0, N, N));
    run("rh_idle", 10, Z);
    // both channels at once; channel 1 released during channel 0 hold
    btn_in = N;
    run("sim_wait", 5, Z);
    step; chk("sim_press", v(CB, CB, N, N, N));
    run("sim_both", 2, v(CB, N, N, N, N));
    btn_in = C1;
    run("sim_rel1_wait", 5, v(CB, N, N, N, N));
    step; chk("sim_rel1", v(C0, N, C1, N, N));
    run("sim_hold_wait", 1, v(C0, N, N, N, N));
    step; chk("sim_hold0", v(C0, N, N, C0, N));
    for (int k = 0; k < 2; k++) begin
      run("sim_rpt_wait", 4, v(C0, N, N, N, N));
      step; chk("sim_rpt0", v(C0, N, N, N, C0));
    end
    btn_in = CB;
    run("sim_rel0_wait", 4, v(C0, N, N, N, N));
    step; chk("sim_rpt0_last", v(C0, N, N, N, C0));
    step; chk("sim_rel0", v(N, N, C0, N, N));
    run("sim_idle", 5, Z);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/btn_reader.md
Name: btn_reader

Overview:
- Input-side counterpart to the board LED output path: conditions the board push-buttons into clean, synchronous control events for the equalizer, such as band select and gain up/down.
- Per channel it does:
  - 2-flop synchronization of the asynchronous pin;
  - counter-based debounce;
  - press/release edge pulses;
  - long-hold detection with auto-repeat pulses.
- Sits between the board KEY pins and the equalizer control FSM.

Parameters:
- WIDTH, 2: number of button channels.
- ACTIVE_LOW, 1: 1 means the pin reads 0 when pressed (board KEYs); 0 means the pin reads 1 when pressed.
- DEBOUNCE_CYCLES, 1000000: consecutive cycles the synchronized level must differ from the stable state before it is accepted (20 ms @ 50 MHz). Must be ≥ 1.
- HOLD_CYCLES, 25000000: cycles of continuous debounced press before hold_pulse (0.5 s). Must be ≥ 1.
- REPEAT_CYCLES, 5000000: period of rpt_pulse after the hold is reached (0.1 s). Must be ≥ 1.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst, input, 1: asynchronous reset, active-high.
- btn_in, input, WIDTH: raw button pins, asynchronous to clk.
- pressed, output, WIDTH: debounced level; 1 = pressed.
- press_pulse, output, WIDTH: one-cycle pulse when pressed rises.
- release_pulse, output, WIDTH: one-cycle pulse when pressed falls.
- hold_pulse, output, WIDTH: one-cycle pulse when a press has lasted HOLD_CYCLES.
- rpt_pulse, output, WIDTH: one-cycle pulse every REPEAT_CYCLES while held past the hold point.

Behaviour:
- Interface decision: one clock (clk); asynchronous, active-high reset (rst).
- All channels are independent and identical; there is no cross-channel interaction.
- Synchronizer: sync1 <= btn_in; sync2 <= sync1. Both flops reset to the inactive pin level (ACTIVE_LOW ? 1 : 0). Define level = sync2 XOR ACTIVE_LOW, so 1 = pressed.
- Debounce (counter deb_cnt, width $clog2(DEBOUNCE_CYCLES+1)):
  - If level == pressed: deb_cnt <= 0.
  - Else if deb_cnt == DEBOUNCE_CYCLES-1: pressed <= level and deb_cnt <= 0.
  - Else: deb_cnt <= deb_cnt + 1.
- Latency: pin changes before edge E0 → pressed toggles at edge E(DEBOUNCE_CYCLES+1).
- Any reversion of level before the count completes restarts the count from 0. No partial credit is kept.
- press_pulse and release_pulse are registered and asserted for exactly the one cycle in which pressed has just changed. They are never both high.
- Hold/repeat state machine (per channel): IDLE, PRESS, HELD.
  - IDLE: entered from any state when pressed == 0.
  - IDLE → PRESS: on pressed rising; hold_cnt <= 0.
  - PRESS: hold_cnt increments each cycle.
  - PRESS → HELD: when hold_cnt == HOLD_CYCLES-1; hold_pulse = 1 for that cycle (exactly HOLD_CYCLES cycles after press_pulse); rpt_cnt <= 0.
  - HELD: rpt_cnt increments each cycle. At rpt_cnt == REPEAT_CYCLES-1: rpt_pulse = 1 and rpt_cnt <= 0. Repeats indefinitely.
  - Any state → IDLE: on pressed falling. Counters clear; no hold_pulse or rpt_pulse in the release cycle or after it.
- Counter widths: $clog2(HOLD_CYCLES+1) and $clog2(REPEAT_CYCLES+1). Neither counter may wrap; they are cleared as specified above.
- Reset values, all channels:
  - pressed = 0; all pulse outputs = 0; state = IDLE; all counters = 0.
  - Synchronizers at the inactive level, so deassertion of rst with the button released produces no spurious press.
- Reset mid-operation clears everything immediately (asynchronously). If the button is still physically down after rst deasserts, it is re-debounced from scratch: press_pulse appears DEBOUNCE_CYCLES+1 edges after the first post-reset edge.
- Pin held pressed through reset → a normal press is detected after reset. This is intended.

Test Plan:
Bench parameters for all scenarios: WIDTH=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5.
- Clean press: btn_in[0] 1→0 before edge E0 → pressed[0]=1 from E5; press_pulse[0] high only in cycle E5–E6; channel 1 outputs stay 0.
- Bounce/glitch: btn_in[0] low 3 cycles, high 1 cycle, then low steady → no change until 4 consecutive pressed samples; exactly one press_pulse. A 3-cycle low glitch alone → no outputs change at all.
- Hold and repeat:
  - keep btn_in[0] low → hold_pulse 10 cycles after press_pulse;
  - rpt_pulse 5, 10 and 15 cycles after hold_pulse;
  - release → release_pulse 5 edges after the pin edge; no further rpt_pulse.
- Short press: release 6 cycles after press_pulse → release_pulse only; no hold_pulse or rpt_pulse.
- Reset mid-hold: assert rst during HELD → all outputs 0 asynchronously. Deassert with the pin still low → press_pulse at post-reset edge 5, hold_pulse 10 cycles later.
- Simultaneous channels: both pins pressed at the same edge → identical, simultaneous pulses. Channel 1 released during channel 0's hold → channel 0 hold/repeat timing is unchanged.
